rpn_stack_ctrl: RTL and testbench

Operand-stack controller for the RPN calculator datapath. It owns a bank of DEPTH load-enabled k-bit stack registers and a depth counter. It sequences push, pop, clear and binary-operation commands from the keypad/decoder front end. For binary operations it presents two operands to the external ALU and writes the ALU result back onto the stack.

---
 rtl/rpn_stack_ctrl_if.sv | 29 ++
 rtl/rpn_stack_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rpn_stack_ctrl_if.sv
// Command/operand bus between the RPN front end, the stack controller and the ALU.
// Ports: cmd_valid/cmd/push_data/alu_result driven by master; cmd_ready, alu_a/b, top, depth, done/err/err_code by slave.
interface rpn_stack_ctrl_if #(
    parameter int k   = 16,
    parameter int SPW = 3
);
    logic           cmd_valid;
    logic [1:0]     cmd;
    logic           cmd_ready;
    logic [k-1:0]   push_data;
    logic [k-1:0]   alu_a;
    logic [k-1:0]   alu_b;
    logic [k-1:0]   alu_result;
    logic [k-1:0]   top;
    logic [SPW-1:0] depth;
    logic           done;
    logic           err;
    logic [1:0]     err_code;

    modport master (
        output cmd_valid, cmd, push_data, alu_result,
        input  cmd_ready, alu_a, alu_b, top, depth, done, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd, push_data, alu_result,
        output cmd_ready, alu_a, alu_b, top, depth, done, err, err_code
    );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// Operand-stack controller: push/pop/clear/binary-op sequencing over DEPTH k-bit entries.
// Ports: clk, reset (sync, active-high), bus (slave side of rpn_stack_ctrl_if).
module rpn_stack_ctrl #(
    parameter int k     = 16,
    parameter int DEPTH = 4,
    parameter int SPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    rpn_stack_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EVAL, WB, RESP} state_t;

    localparam logic [1:0] CMD_PUSH = 2'b00;
    localparam logic [1:0] CMD_POP  = 2'b01;
    localparam logic [1:0] CMD_BIN  = 2'b10;
    localparam logic [1:0] CMD_CLR  = 2'b11;

    localparam logic [SPW-1:0] FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] ONE  = SPW'(1);
    localparam logic [SPW-1:0] TWO  = SPW'(2);

    state_t           state;
    state_t           next;
    logic [k-1:0]     stack [DEPTH];
    logic [SPW-1:0]   cnt;
    logic [SPW-1:0]   cnt_next;
    logic             ready;
    logic             accept;
    logic             full;
    logic             empty;
    logic             few;
    logic [1:0]       fault;
    logic [DEPTH-1:0] we;
    logic [k-1:0]     wdata;
    logic             load_ops;
    logic [k-1:0]     opnd_a;
    logic [k-1:0]     top_val;
    logic [k-1:0]     alu_a;
    logic [k-1:0]     alu_b;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    function automatic logic [DEPTH-1:0] dec(input logic [SPW-1:0] idx);
        logic [DEPTH-1:0] sel;
        sel = '0;
        for (int i = 0; i < DEPTH; i++)
            sel[i] = (SPW'(i) == idx);
        return sel;
    endfunction

    assign accept = bus.cmd_valid && ready;
    assign full   = (cnt == FULL);
    assign empty  = (cnt == '0);
    assign few    = (cnt < TWO);

    // Fault classification of the command currently on the bus.
    always_comb begin
        fault = 2'b00;
        case (bus.cmd)
            CMD_PUSH: if (full)  fault = 2'b01;
            CMD_POP:  if (empty) fault = 2'b10;
            CMD_BIN:  if (few)   fault = 2'b10;
            default:  fault = 2'b00;
        endcase
    end

    // Read muxes; top falls to 0 on an empty stack since no i+1 matches 0.
    always_comb begin
        opnd_a  = '0;
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (SPW'(i) == cnt - TWO)
                opnd_a = stack[i];
            if (SPW'(i + 1) == cnt)
                top_val = stack[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: if (accept)
                      next = (bus.cmd == CMD_BIN && !few) ? EVAL : RESP;
            EVAL:    next = WB;
            WB:      next = RESP;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == IDLE);
        we       = '0;
        wdata    = '0;
        cnt_next = cnt;
        load_ops = 1'b0;
        case (state)
            IDLE: if (accept) begin
                case (bus.cmd)
                    CMD_PUSH: if (!full) begin
                        we       = dec(cnt);
                        wdata    = bus.push_data;
                        cnt_next = cnt + ONE;
                    end
                    CMD_POP: if (!empty)
                        cnt_next = cnt - ONE;
                    CMD_BIN:
                        load_ops = !few;
                    default: begin
                        we       = '1;
                        cnt_next = '0;
                    end
                endcase
            end
            WB: begin
                we       = dec(cnt - TWO);
                wdata    = bus.alu_result;
                cnt_next = cnt - ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                stack[i] <= '0;
        end else begin
            cnt <= cnt_next;
            for (int i = 0; i < DEPTH; i++)
                if (we[i])
                    stack[i] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a <= '0;
            alu_b <= '0;
        end else if (load_ops) begin
            alu_a <= opnd_a;
            alu_b <= top_val;
        end
    end

    // Only a command finishing straight from IDLE can carry a fault code.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            done     <= (next == RESP);
            err      <= accept && (fault != 2'b00);
            err_code <= accept ? fault : 2'b00;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.top       = top_val;
    assign bus.depth     = cnt;
    assign bus.done      = done;
    assign bus.err       = err;
    assign bus.err_code  = err_code;
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl: vector table plus hand sequences for EVAL and reset abort.
// Ports: none (top-level bench; bench-side ALU computes a+b).
module tb_rpn_stack_ctrl;
    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] BIN  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] data;
        bit          hold;
        int          lat;
        logic        err;
        logic [1:0]  code;
        logic [2:0]  depth;
        logic [15:0] top;
    } vec_t;

    logic clk = 0;
    logic reset = 1;
    int   checks = 0;
    int   failures = 0;
    int   accepts = 0;
    vec_t v [24];

    rpn_stack_ctrl_if #(.k(16), .SPW(3)) bus ();

    rpn_stack_ctrl #(.k(16), .DEPTH(4), .SPW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.alu_result = bus.alu_a + bus.alu_b;

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.cmd_valid && bus.cmd_ready && !reset)
            accepts++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input logic [15:0] d,
                         input bit hold);
        int n = 0;
        bus.cmd = c;
        bus.push_data = d;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        if (!hold)
            bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        issue(v[i].cmd, v[i].data, v[i].hold);
        wait_done(lat);
        chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
        chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(v[i].err));
        chk($sformatf("v%0d_code", i), 32'(bus.err_code), 32'(v[i].code));
        chk($sformatf("v%0d_depth", i), 32'(bus.depth), 32'(v[i].depth));
        chk($sformatf("v%0d_top", i), 32'(bus.top), 32'(v[i].top));
    endtask

    initial begin
        int lat;
        int acc0;
        bit saw_done;

        v[0]  = '{PUSH, 16'd5,      0, 1, 0, 2'b00, 3'd1, 16'd5};
        v[1]  = '{PUSH, 16'd7,      0, 1, 0, 2'b00, 3'd2, 16'd7};
        v[2]  = '{PUSH, 16'd9,      0, 1, 0, 2'b00, 3'd3, 16'd9};
        v[3]  = '{POP,  16'd0,      0, 1, 0, 2'b00, 3'd1, 16'd5};
        v[4]  = '{CLR,  16'd0,      0, 1, 0, 2'b00, 3'd0, 16'd0};
        v[5]  = '{PUSH, 16'd1,      0, 1, 0, 2'b00, 3'd1, 16'd1};
        v[6]  = '{PUSH, 16'd2,      0, 1, 0, 2'b00, 3'd2, 16'd2};
        v[7]  = '{PUSH, 16'd3,      0, 1, 0, 2'b00, 3'd3, 16'd3};
        v[8]  = '{PUSH, 16'd4,      0, 1, 0, 2'b00, 3'd4, 16'd4};
        v[9]  = '{PUSH, 16'd5,      0, 1, 1, 2'b01, 3'd4, 16'd4};
        v[10] = '{CLR,  16'd0,      0, 1, 0, 2'b00, 3'd0, 16'd0};
        v[11] = '{POP,  16'd0,      0, 1, 1, 2'b10, 3'd0, 16'd0};
        v[12] = '{PUSH, 16'd3,      0, 1, 0, 2'b00, 3'd1, 16'd3};
        v[13] = '{BIN,  16'd0,      0, 1, 1, 2'b10, 3'd1, 16'd3};
        v[14] = '{CLR,  16'd0,      0, 1, 0, 2'b00, 3'd0, 16'd0};
        v[15] = '{PUSH, 16'd2,      0, 1, 0, 2'b00, 3'd1, 16'd2};
        v[16] = '{PUSH, 16'd6,      0, 1, 0, 2'b00, 3'd2, 16'd6};
        v[17] = '{PUSH, 16'd1,      1, 1, 0, 2'b00, 3'd1, 16'd1};
        v[18] = '{PUSH, 16'd2,      1, 1, 0, 2'b00, 3'd2, 16'd2};
        v[19] = '{PUSH, 16'd3,      1, 1, 0, 2'b00, 3'd3, 16'd3};
        v[20] = '{CLR,  16'd0,      1, 1, 0, 2'b00, 3'd0, 16'd0};
        v[21] = '{PUSH, 16'hFFFF,   1, 1, 0, 2'b00, 3'd1, 16'hFFFF};
        v[22] = '{PUSH, 16'h0001,   1, 1, 0, 2'b00, 3'd2, 16'h0001};
        v[23] = '{BIN,  16'd0,      1, 3, 0, 2'b00, 3'd1, 16'h0000};

        bus.cmd_valid = 1'b0;
        bus.cmd = 2'b00;
        bus.push_data = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_depth", 32'(bus.depth), 32'd0);
        chk("rst_top", 32'(bus.top), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);

        for (int i = 0; i <= 2; i++)
            run_vec(i);

        issue(BIN, 16'd0, 0);
        chk("eval_alu_a", 32'(bus.alu_a), 32'd7);
        chk("eval_alu_b", 32'(bus.alu_b), 32'd9);
        chk("eval_result", 32'(bus.alu_result), 32'd16);
        chk("eval_done", 32'(bus.done), 32'd0);
        wait_done(lat);
        chk("bin_lat", 32'(lat), 32'd3);
        chk("bin_err", 32'(bus.err), 32'd0);
        chk("bin_depth", 32'(bus.depth), 32'd2);
        chk("bin_top", 32'(bus.top), 32'd16);

        for (int i = 3; i <= 16; i++)
            run_vec(i);

        issue(BIN, 16'd0, 0);
        chk("abort_alu_a", 32'(bus.alu_a), 32'd2);
        chk("abort_alu_b", 32'(bus.alu_b), 32'd6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_depth", 32'(bus.depth), 32'd0);
        chk("abort_top", 32'(bus.top), 32'd0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        saw_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done || bus.depth != 3'd0)
                saw_done = 1;
            @(posedge clk); #1;
        end
        chk("abort_quiet", 32'(saw_done), 32'd0);

        acc0 = accepts;
        for (int i = 17; i <= 23; i++)
            run_vec(i);
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_accepts", 32'(accepts - acc0), 32'd7);
        chk("hold_depth", 32'(bus.depth), 32'd1);
        chk("hold_top", 32'(bus.top), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
